pc_fetch: RTL and testbench

Instruction fetch stage of the 8-bit processor. Holds the program counter, runs a request/acknowledge handshake with program memory, and presents one fetched instruction at a time to the decoder through a valid/ready handshake. The next-PC value is chosen by an 8-bit 2:1 mux: increment path or jump target. The decoder/execute stage drives jump requests back into this block.

---
 rtl/pc_fetch_pkg.sv | 15 +
 rtl/mux2x8.sv | 12 +
 rtl/pc_fetch.sv | 154 +++++++++++++++
 tb/tb_pc_fetch.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: state encoding and defaults.
package pc_fetch_pkg;

    localparam int         FETCH_ADDR_W   = 8;
    localparam int         FETCH_DATA_W   = 8;
    localparam logic [7:0] FETCH_RESET_PC = 8'h00;

    // Fetch sequencer states (2-bit encoding).
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        HOLD  = 2'b10
    } fetch_state_t;

endpackage

// File: rtl/mux2x8.sv
// 8-bit 2:1 multiplexer: address=0 selects in0, address=1 selects in1.
module mux2x8 (
    input  logic       address,
    input  logic [7:0] in0,
    input  logic [7:0] in1,
    output logic [7:0] y
);

    // Plain combinational select.
    assign y = address ? in1 : in0;

endmodule

// File: rtl/pc_fetch.sv
// Instruction fetch stage: program counter, memory req/ack handshake and a
// single-entry valid/ready output towards the decoder. Jumps from execute
// redirect the PC; an in-flight request is allowed to finish and its data is
// dropped rather than cancelling the memory handshake.
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter int         ADDR_W   = FETCH_ADDR_W,
    parameter int         DATA_W   = FETCH_DATA_W,
    parameter logic [7:0] RESET_PC = FETCH_RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [ADDR_W-1:0] pc
);

    fetch_state_t      state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic              mem_req_reg, mem_req_next;
    logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic [DATA_W-1:0] instr_reg, instr_next;
    logic [ADDR_W-1:0] instr_pc_reg, instr_pc_next;
    logic              instr_valid_reg, instr_valid_next;
    logic              discard_reg, discard_next;
    logic              pc_inc;
    logic [ADDR_W-1:0] pc_plus1;
    logic [ADDR_W-1:0] pc_sel;

    // Increment wraps naturally modulo 2^ADDR_W.
    assign pc_plus1 = pc_reg + 1'b1;

    // Next-PC source: jump target wins over the increment path.
    mux2x8 u_next_pc_mux (
        .address (jump_en),
        .in0     (pc_plus1),
        .in1     (jump_addr),
        .y       (pc_sel)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and next-output logic for the fetch sequencer.
    always_comb begin
        state_next       = state_reg;
        mem_req_next     = mem_req_reg;
        instr_next       = instr_reg;
        instr_pc_next    = instr_pc_reg;
        instr_valid_next = instr_valid_reg;
        discard_next     = discard_reg;
        pc_inc           = 1'b0;

        case (state_reg)
            IDLE: begin
                if (enable) begin
                    state_next   = FETCH;
                    mem_req_next = 1'b1;
                end
            end
            FETCH: begin
                if (mem_ack) begin
                    mem_req_next = 1'b0;
                    if (discard_reg || jump_en) begin
                        // Data belongs to the pre-jump stream: drop it.
                        discard_next = 1'b0;
                        state_next   = IDLE;
                    end else begin
                        instr_next       = mem_rdata;
                        instr_pc_next    = pc_reg;
                        instr_valid_next = 1'b1;
                        pc_inc           = 1'b1;
                        state_next       = HOLD;
                    end
                end else if (jump_en) begin
                    // Let the outstanding request finish, but mark it stale.
                    discard_next = 1'b1;
                end
            end
            HOLD: begin
                if (jump_en) begin
                    // Flush; a simultaneous ready still counts as accepted.
                    instr_valid_next = 1'b0;
                    state_next       = IDLE;
                end else if (instr_ready) begin
                    instr_valid_next = 1'b0;
                    if (enable) begin
                        state_next   = FETCH;
                        mem_req_next = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        pc_next = (pc_inc || jump_en) ? pc_sel : pc_reg;

        // Address tracks the PC except while a request is waiting for ack.
        if (state_reg == FETCH && !mem_ack) begin
            mem_addr_next = mem_addr_reg;
        end else begin
            mem_addr_next = pc_next;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg          <= RESET_PC;
            mem_req_reg     <= 1'b0;
            mem_addr_reg    <= '0;
            instr_reg       <= '0;
            instr_pc_reg    <= '0;
            instr_valid_reg <= 1'b0;
            discard_reg     <= 1'b0;
        end else begin
            pc_reg          <= pc_next;
            mem_req_reg     <= mem_req_next;
            mem_addr_reg    <= mem_addr_next;
            instr_reg       <= instr_next;
            instr_pc_reg    <= instr_pc_next;
            instr_valid_reg <= instr_valid_next;
            discard_reg     <= discard_next;
        end
    end

    assign pc          = pc_reg;
    assign mem_req     = mem_req_reg;
    assign mem_addr    = mem_addr_reg;
    assign instr       = instr_reg;
    assign instr_pc    = instr_pc_reg;
    assign instr_valid = instr_valid_reg;

endmodule

// File: tb/tb_pc_fetch.sv
// Randomised scoreboard bench for pc_fetch. The driver acts as program memory
// and execute stage; the monitor keeps an architectural model (expected next
// fetch address plus queue of instructions owed to the decoder).
module tb_pc_fetch;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       jump_en = 1'b0;
    logic [7:0] jump_addr = 8'h00;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic       mem_ack = 1'b0;
    logic [7:0] mem_rdata = 8'h00;
    logic [7:0] instr;
    logic [7:0] instr_pc;
    logic       instr_valid;
    logic       instr_ready = 1'b0;
    logic [7:0] pc;

    pc_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .jump_en     (jump_en),
        .jump_addr   (jump_addr),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc          (pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic [7:0] a;
    } exp_t;

    int         vectors = 0;
    int         errors  = 0;
    logic [7:0] memtab [256];
    exp_t       expq [$];

    // model state (monitor only)
    logic [7:0] model_pc = 8'h00;
    bit         req_open = 1'b0;
    bit         tainted  = 1'b0;
    logic [7:0] req_addr = 8'h00;
    int         cyc      = 0;
    int         last_acc = -1;
    bit         stream_d = 1'b0;
    bit         acc, ack;
    exp_t       e;

    // driver knobs
    bit         stream_mode = 1'b0;
    int         lat_min = 0, lat_max = 0;
    int         p_en = 0, p_ready = 0, p_jump = 0;
    bit         in_req = 1'b0;
    int         cnt = 0, tgt = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: sample at negedge, compare, then advance the model to what the
    // coming posedge should produce.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            expq.delete();
            model_pc = 8'h00;
            req_open = 1'b0;
            tainted  = 1'b0;
            last_acc = -1;
        end else begin
            check("pc", pc, model_pc);
            check("instr_valid", instr_valid, expq.size() != 0);
            if (mem_req && !req_open) begin
                check("req_addr", mem_addr, model_pc);
                req_open = 1'b1;
                tainted  = 1'b0;
                req_addr = model_pc;
            end else if (mem_req) begin
                check("addr_stable", mem_addr, req_addr);
            end
            if (stream_mode && !stream_d) last_acc = -1;
            stream_d = stream_mode;
            acc = instr_valid && instr_ready;
            if (acc) begin
                if (expq.size() == 0) begin
                    check("unexpected_instr", 1, 0);
                end else begin
                    e = expq.pop_front();
                    check("instr", instr, e.d);
                    check("instr_pc", instr_pc, e.a);
                    $display("accept instr=%02h pc=%02h (exp %02h/%02h) cyc=%0d",
                             instr, instr_pc, e.d, e.a, cyc);
                    if (stream_mode && last_acc >= 0)
                        check("throughput", cyc - last_acc, 2);
                    last_acc = cyc;
                end
            end
            ack = mem_req && mem_ack;
            if (ack) begin
                req_open = 1'b0;
                if (!jump_en && !tainted) begin
                    e.d = memtab[req_addr];
                    e.a = req_addr;
                    expq.push_back(e);
                    model_pc = req_addr + 8'd1;
                end
            end
            if (jump_en) begin
                model_pc = jump_addr;
                if (req_open) tainted = 1'b1;
                if (!acc && expq.size() != 0) void'(expq.pop_front());
            end
        end
    end

    // One clock of stimulus: memory responder plus random control inputs.
    task automatic step();
        @(posedge clk);
        #1;
        if (mem_req) begin
            if (!in_req) begin
                in_req = 1'b1;
                cnt    = 0;
                tgt    = $urandom_range(lat_max, lat_min);
            end
            mem_ack   = (cnt >= tgt);
            cnt++;
            mem_rdata = memtab[mem_addr];
        end else begin
            in_req    = 1'b0;
            mem_ack   = ($urandom_range(99, 0) < 10);
            mem_rdata = 8'($urandom);
        end
        enable      = ($urandom_range(99, 0) < p_en);
        instr_ready = ($urandom_range(99, 0) < p_ready);
        jump_en     = ($urandom_range(99, 0) < p_jump);
        jump_addr   = ($urandom_range(3, 0) == 0) ? 8'hFF : 8'($urandom);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) memtab[i] = 8'($urandom);
        memtab[0] = 8'hA1;
        memtab[1] = 8'hA2;
        memtab[2] = 8'hA3;

        // power-on reset, checked before any clock edge
        #3;
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_instr", instr, 0);
        check("rst_instr_pc", instr_pc, 0);
        check("rst_instr_valid", instr_valid, 0);
        check("rst_pc", pc, 0);
        step();
        step();
        rst = 1'b0;

        // streaming: zero-latency memory, decoder always ready
        p_en = 100; p_ready = 100; p_jump = 0; lat_min = 0; lat_max = 0;
        stream_mode = 1'b1;
        for (int i = 0; i < 14; i++) step();
        stream_mode = 1'b0;

        // wrap: jump to 0xFF then keep streaming through 0x00
        step();
        jump_en = 1'b1;
        jump_addr = 8'hFF;
        for (int i = 0; i < 10; i++) step();

        // randomised mix of latency, backpressure, enable and jumps
        p_en = 80; p_ready = 60; p_jump = 10; lat_min = 0; lat_max = 3;
        for (int i = 0; i < 2000; i++) step();
        p_en = 60; p_ready = 20; p_jump = 4; lat_min = 0; lat_max = 6;
        for (int i = 0; i < 1000; i++) step();

        // drain
        p_en = 0; p_ready = 100; p_jump = 0; lat_min = 0; lat_max = 2;
        for (int i = 0; i < 20; i++) step();
        check("drain_queue_empty", expq.size(), 0);
        check("drain_valid", instr_valid, 0);

        // asynchronous reset mid-FETCH at pc=0x23
        step();
        jump_en = 1'b1;
        jump_addr = 8'h23;
        lat_min = 20; lat_max = 20; p_en = 100;
        for (int i = 0; i < 4; i++) step();
        check("pre_rst_pc", pc, 8'h23);
        check("pre_rst_req", mem_req, 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_mem_req", mem_req, 0);
        check("arst_instr_valid", instr_valid, 0);
        check("arst_mem_addr", mem_addr, 0);
        check("arst_pc", pc, 0);
        step();
        step();
        rst = 1'b0;

        // short random run after reset
        p_en = 80; p_ready = 70; p_jump = 10; lat_min = 0; lat_max = 3;
        for (int i = 0; i < 300; i++) step();
        p_en = 0; p_ready = 100; p_jump = 0; lat_min = 0; lat_max = 2;
        for (int i = 0; i < 20; i++) step();
        check("final_queue_empty", expq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
